// File: rtl/lsu_align_unit_if.sv
// Pipeline-request, load/store response and data-memory port bundle for lsu_align_unit.
// The slave side is the align unit; the master side is the pipeline plus memory.
interface lsu_align_unit_if #(
   parameter int ADDR_W = 9
) ();
   logic              req_valid;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              busy;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_strb;
   logic [31:0]       mem_rdata;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      output busy, resp_valid, resp_rdata, resp_err,
      output mem_we, mem_addr, mem_wdata, mem_strb
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      input  busy, resp_valid, resp_rdata, resp_err,
      input  mem_we, mem_addr, mem_wdata, mem_strb
   );
endinterface

// File: rtl/lsu_align_unit.sv
// MEM-stage load/store aligner: byte strobes, lane shifting, load extension, and
// splitting of word-crossing half/word accesses into two aligned accesses.
module lsu_align_unit #(
   parameter int ADDR_W = 9,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              reset,
   lsu_align_unit_if.slave   bus
);
   typedef enum logic {IDLE = 1'b0, HI = 1'b1} state_t;

   state_t            state_reg, state_next;

   logic              lat_we_reg;
   logic [2:0]        lat_funct3_reg;
   logic [1:0]        lat_off_reg;
   logic [ADDR_W-1:0] lat_addr_reg;
   logic [3:0]        lat_strb_hi_reg;
   logic [XLEN-1:0]   lat_wdata_hi_reg;
   logic [XLEN-1:0]   lo_reg;
   logic [XLEN-1:0]   resp_rdata_reg;
   logic              resp_valid_reg;
   logic              resp_err_reg;

   logic [1:0]        off;
   logic [3:0]        size_mask;
   logic [7:0]        byte_mask;
   logic              legal;
   logic              split;
   logic [2*XLEN-1:0] wdata_shift;
   logic [XLEN-1:0]   lo_word;
   logic [XLEN-1:0]   hi_word;
   logic              accept_split;

   logic              busy_c;
   logic              we_c;
   logic [ADDR_W-1:0] addr_c;
   logic [3:0]        strb_c;
   logic [XLEN-1:0]   wdata_c;
   logic              ld_fire;
   logic [2:0]        ld_f3;
   logic [XLEN-1:0]   ld_word;
   logic              err_fire;

   logic              unused_addr;
   assign unused_addr = ^bus.req_addr[31:ADDR_W];

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
      case (f3)
         3'b000:  extend = {{24{w[7]}}, w[7:0]};
         3'b001:  extend = {{16{w[15]}}, w[15:0]};
         3'b100:  extend = {24'h0, w[7:0]};
         3'b101:  extend = {16'h0, w[15:0]};
         default: extend = w;
      endcase
   endfunction

   always_comb begin
      off = bus.req_addr[1:0];
      case (bus.req_funct3[1:0])
         2'b00:   size_mask = 4'b0001;
         2'b01:   size_mask = 4'b0011;
         default: size_mask = 4'b1111;
      endcase
      case (bus.req_funct3)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b100, 3'b101:         legal = !bus.req_we;
         default:                legal = 1'b0;
      endcase
      byte_mask   = {4'h0, size_mask} << off;
      split       = |byte_mask[7:4];
      // Upper half of the 64-bit shift is exactly the data for the second access.
      wdata_shift = {{XLEN{1'b0}}, bus.req_wdata} << {off, 3'b000};
      lo_word     = bus.mem_rdata >> {off, 3'b000};
      hi_word     = XLEN'({bus.mem_rdata, lo_reg} >> {lat_off_reg, 3'b000});
   end

   assign accept_split = (state_reg == IDLE) && bus.req_valid && legal && split;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept_split) state_next = HI;
         HI:   state_next = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy_c   = 1'b0;
      we_c     = 1'b0;
      addr_c   = '0;
      strb_c   = 4'h0;
      wdata_c  = '0;
      ld_fire  = 1'b0;
      ld_f3    = bus.req_funct3;
      ld_word  = lo_word;
      err_fire = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.req_valid) begin
               if (legal) begin
                  addr_c  = {bus.req_addr[ADDR_W-1:2], 2'b00};
                  strb_c  = bus.req_we ? byte_mask[3:0] : 4'hF;
                  wdata_c = wdata_shift[XLEN-1:0];
                  we_c    = bus.req_we;
                  busy_c  = split;
                  ld_fire = !bus.req_we && !split;
               end else begin
                  err_fire = 1'b1;
               end
            end
         end
         HI: begin
            addr_c  = lat_addr_reg + ADDR_W'(4);
            strb_c  = lat_we_reg ? lat_strb_hi_reg : 4'hF;
            wdata_c = lat_wdata_hi_reg;
            we_c    = lat_we_reg;
            ld_fire = !lat_we_reg;
            ld_f3   = lat_funct3_reg;
            ld_word = hi_word;
         end
      endcase
      // Reset must silence the memory port immediately, including mid-split.
      if (!reset) begin
         busy_c = 1'b0;
         we_c   = 1'b0;
         strb_c = 4'h0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lat_we_reg       <= 1'b0;
         lat_funct3_reg   <= 3'h0;
         lat_off_reg      <= 2'h0;
         lat_addr_reg     <= '0;
         lat_strb_hi_reg  <= 4'h0;
         lat_wdata_hi_reg <= '0;
         lo_reg           <= '0;
         resp_rdata_reg   <= '0;
         resp_valid_reg   <= 1'b0;
         resp_err_reg     <= 1'b0;
      end else begin
         resp_valid_reg <= ld_fire;
         resp_err_reg   <= err_fire;
         if (ld_fire) begin
            resp_rdata_reg <= extend(ld_f3, ld_word);
         end
         if (accept_split) begin
            lat_we_reg       <= bus.req_we;
            lat_funct3_reg   <= bus.req_funct3;
            lat_off_reg      <= off;
            lat_addr_reg     <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            lat_strb_hi_reg  <= byte_mask[7:4];
            lat_wdata_hi_reg <= wdata_shift[2*XLEN-1:XLEN];
            if (!bus.req_we) begin
               lo_reg <= bus.mem_rdata;
            end
         end
      end
   end

   assign bus.busy       = busy_c;
   assign bus.mem_we     = we_c;
   assign bus.mem_addr   = addr_c;
   assign bus.mem_strb   = strb_c;
   assign bus.mem_wdata  = wdata_c;
   assign bus.resp_valid = resp_valid_reg;
   assign bus.resp_rdata = resp_rdata_reg;
   assign bus.resp_err   = resp_err_reg;
endmodule

// File: tb/tb_lsu_align_unit.sv
// Self-checking bench for lsu_align_unit: directed vector table, hand-written corner
// sequences, random traffic against a byte-level memory model, and a response scoreboard.
module tb_lsu_align_unit;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   lsu_align_unit_if #(.ADDR_W(9)) bus ();

   lsu_align_unit #(.ADDR_W(9), .XLEN(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Data memory seen by the DUT: combinational read, strobed synchronous write.
   logic [31:0] ram [0:127] = '{default: 32'h0};
   assign bus.mem_rdata = ram[bus.mem_addr[8:2]];
   always @(posedge clk) begin
      if (bus.mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.mem_strb[b]) ram[bus.mem_addr[8:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
         end
      end
   end

   // Reference byte memory updated at stimulus time.
   logic [7:0] ref_mem [0:511] = '{default: 8'h0};

   int errors = 0;
   int checks = 0;
   int cycle  = 0;
   always @(posedge clk) cycle <= cycle + 1;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [8:0]  addr;
      logic [31:0] wdata;
      logic        split;
      logic [8:0]  a0;
      logic [3:0]  s0;
      logic [31:0] w0;
      logic [8:0]  a1;
      logic [3:0]  s1;
      logic [31:0] w1;
      logic [31:0] rdata;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Response monitor: every load result must appear on its due cycle, nothing else.
   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0].due < cycle) begin
         checks++;
         errors++;
         $display("FAIL resp_missing: no response by cycle %0d expected %h", sb[0].due, sb[0].data);
         void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cycle) begin
         checks++;
         if (bus.resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL resp_valid: got %b expected 1 (data %h) at cycle %0d", bus.resp_valid, sb[0].data, cycle);
         end else if (bus.resp_rdata !== sb[0].data) begin
            errors++;
            $display("FAIL resp_rdata: got %h expected %h at cycle %0d", bus.resp_rdata, sb[0].data, cycle);
         end else begin
            $display("resp ok: %h at cycle %0d", bus.resp_rdata, cycle);
         end
         void'(sb.pop_front());
      end else if (bus.resp_valid === 1'b1) begin
         checks++;
         errors++;
         $display("FAIL resp_unexpected: got resp_valid=1 data %h expected no response at cycle %0d", bus.resp_rdata, cycle);
      end
   end

   function automatic int nbytes(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [8:0] addr);
      logic [31:0] w;
      w = 32'h0;
      for (int i = 0; i < nbytes(f3); i++) w[8*i +: 8] = ref_mem[9'(addr + 9'(i))];
      if (f3 == 3'b000 && w[7])  w = w | 32'hFFFFFF00;
      if (f3 == 3'b001 && w[15]) w = w | 32'hFFFF0000;
      return w;
   endfunction

   task automatic model_store(input vec_t v);
      for (int i = 0; i < nbytes(v.f3); i++) ref_mem[9'(v.addr + 9'(i))] = v.wdata[8*i +: 8];
   endtask

   // Drive one request at a falling edge and hold it for as many cycles as it occupies.
   task automatic issue(input vec_t v, input bit chk_acc, input string tag);
      bus.req_valid  = 1'b1;
      bus.req_we     = v.we;
      bus.req_funct3 = v.f3;
      bus.req_addr   = {23'h0, v.addr};
      bus.req_wdata  = v.wdata;
      #1;
      $display("req %s: we=%0b f3=%0d addr=%h wdata=%h", tag, v.we, v.f3, v.addr, v.wdata);
      chk({tag, "_busy0"}, {31'h0, bus.busy}, {31'h0, v.split});
      if (chk_acc) begin
         chk({tag, "_addr0"}, {23'h0, bus.mem_addr}, {23'h0, v.a0});
         chk({tag, "_strb0"}, {28'h0, bus.mem_strb}, {28'h0, v.s0});
         chk({tag, "_we0"}, {31'h0, bus.mem_we}, {31'h0, v.we});
         if (v.we) chk({tag, "_wdata0"}, bus.mem_wdata, v.w0);
      end
      if (!v.we) sb.push_back(exp_t'{v.rdata, cycle + (v.split ? 2 : 1)});
      else model_store(v);
      @(negedge clk);
      if (v.split) begin
         #1;
         chk({tag, "_busy1"}, {31'h0, bus.busy}, 32'h0);
         if (chk_acc) begin
            chk({tag, "_addr1"}, {23'h0, bus.mem_addr}, {23'h0, v.a1});
            chk({tag, "_strb1"}, {28'h0, bus.mem_strb}, {28'h0, v.s1});
            chk({tag, "_we1"}, {31'h0, bus.mem_we}, {31'h0, v.we});
            if (v.we) chk({tag, "_wdata1"}, bus.mem_wdata, v.w1);
         end
         @(negedge clk);
      end
   endtask

   task automatic illegal(input logic we, input logic [2:0] f3, input string tag);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = 32'h0000_0010;
      bus.req_wdata  = 32'hCAFEF00D;
      #1;
      $display("req %s: illegal we=%0b f3=%0d", tag, we, f3);
      chk({tag, "_we"}, {31'h0, bus.mem_we}, 32'h0);
      chk({tag, "_busy"}, {31'h0, bus.busy}, 32'h0);
      @(negedge clk);
      bus.req_valid = 1'b0;
      #1;
      chk({tag, "_err_pulse"}, {31'h0, bus.resp_err}, 32'h1);
      @(negedge clk);
      #1;
      chk({tag, "_err_clear"}, {31'h0, bus.resp_err}, 32'h0);
      @(negedge clk);
   endtask

   vec_t tbl [16];
   vec_t v;

   initial begin
      tbl[0]  = '{1'b1, 3'd2, 9'h010, 32'hDEADBEEF, 1'b0, 9'h010, 4'hF, 32'hDEADBEEF, 9'h0, 4'h0, 32'h0, 32'h0};
      tbl[1]  = '{1'b0, 3'd2, 9'h010, 32'h0,        1'b0, 9'h010, 4'hF, 32'h0, 9'h0, 4'h0, 32'h0, 32'hDEADBEEF};
      tbl[2]  = '{1'b1, 3'd2, 9'h020, 32'h80FF7F01, 1'b0, 9'h020, 4'hF, 32'h80FF7F01, 9'h0, 4'h0, 32'h0, 32'h0};
      tbl[3]  = '{1'b0, 3'd0, 9'h023, 32'h0,        1'b0, 9'h020, 4'hF, 32'h0, 9'h0, 4'h0, 32'h0, 32'hFFFFFF80};
      tbl[4]  = '{1'b0, 3'd4, 9'h023, 32'h0,        1'b0, 9'h020, 4'hF, 32'h0, 9'h0, 4'h0, 32'h0, 32'h00000080};
      tbl[5]  = '{1'b0, 3'd1, 9'h022, 32'h0,        1'b0, 9'h020, 4'hF, 32'h0, 9'h0, 4'h0, 32'h0, 32'hFFFF80FF};
      tbl[6]  = '{1'b0, 3'd5, 9'h022, 32'h0,        1'b0, 9'h020, 4'hF, 32'h0, 9'h0, 4'h0, 32'h0, 32'h000080FF};
      tbl[7]  = '{1'b1, 3'd0, 9'h025, 32'h000000AB, 1'b0, 9'h024, 4'b0010, 32'h0000AB00, 9'h0, 4'h0, 32'h0, 32'h0};
      tbl[8]  = '{1'b1, 3'd2, 9'h031, 32'h44332211, 1'b1, 9'h030, 4'b1110, 32'h33221100, 9'h034, 4'b0001, 32'h00000044, 32'h0};
      tbl[9]  = '{1'b0, 3'd2, 9'h031, 32'h0,        1'b1, 9'h030, 4'hF, 32'h0, 9'h034, 4'hF, 32'h0, 32'h44332211};
      tbl[10] = '{1'b1, 3'd1, 9'h037, 32'h0000BEEF, 1'b1, 9'h034, 4'b1000, 32'hEF000000, 9'h038, 4'b0001, 32'h000000BE, 32'h0};
      tbl[11] = '{1'b0, 3'd1, 9'h037, 32'h0,        1'b1, 9'h034, 4'hF, 32'h0, 9'h038, 4'hF, 32'h0, 32'hFFFFBEEF};
      tbl[12] = '{1'b1, 3'd2, 9'h1FE, 32'hAABBCCDD, 1'b1, 9'h1FC, 4'b1100, 32'hCCDD0000, 9'h000, 4'b0011, 32'h0000AABB, 32'h0};
      tbl[13] = '{1'b0, 3'd2, 9'h1FE, 32'h0,        1'b1, 9'h1FC, 4'hF, 32'h0, 9'h000, 4'hF, 32'h0, 32'hAABBCCDD};
      tbl[14] = '{1'b0, 3'd4, 9'h025, 32'h0,        1'b0, 9'h024, 4'hF, 32'h0, 9'h0, 4'h0, 32'h0, 32'h000000AB};
      tbl[15] = '{1'b0, 3'd2, 9'h024, 32'h0,        1'b0, 9'h024, 4'hF, 32'h0, 9'h0, 4'h0, 32'h0, 32'h0000AB00};

      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'h0;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      repeat (2) @(negedge clk);

      // Outputs stay quiet while reset is held even with a request present.
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_funct3 = 3'd2;
      bus.req_addr   = 32'h0000_0011;
      #1;
      chk("rst_busy", {31'h0, bus.busy}, 32'h0);
      chk("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
      chk("rst_strb", {28'h0, bus.mem_strb}, 32'h0);
      chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      chk("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
      bus.req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      chk("idle_we", {31'h0, bus.mem_we}, 32'h0);
      chk("idle_strb", {28'h0, bus.mem_strb}, 32'h0);
      chk("idle_addr", {23'h0, bus.mem_addr}, 32'h0);
      chk("idle_busy", {31'h0, bus.busy}, 32'h0);
      @(negedge clk);

      for (int i = 0; i < 16; i++) issue(tbl[i], 1'b1, $sformatf("v%0d", i));

      // A store must leave the previous load result in place.
      v = '{1'b1, 3'd2, 9'h100, 32'h12345678, 1'b0, 9'h100, 4'hF, 32'h12345678, 9'h0, 4'h0, 32'h0, 32'h0};
      issue(v, 1'b1, "hold_sw");
      #1;
      chk("hold_rdata", bus.resp_rdata, 32'h0000AB00);
      bus.req_valid = 1'b0;
      @(negedge clk);

      illegal(1'b0, 3'b011, "ill_ld011");
      illegal(1'b1, 3'b100, "ill_sbu");

      // Reset asserted during the second half of a split store.
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_funct3 = 3'd2;
      bus.req_addr   = 32'h0000_00F1;
      bus.req_wdata  = 32'h11223344;
      #1;
      $display("req rst_split: SW addr 0f1 wdata 11223344, reset during second access");
      chk("rsplit_busy0", {31'h0, bus.busy}, 32'h1);
      @(posedge clk);
      #2;
      chk("rsplit_hi_we", {31'h0, bus.mem_we}, 32'h1);
      reset = 1'b0;
      #1;
      chk("rsplit_we", {31'h0, bus.mem_we}, 32'h0);
      chk("rsplit_busy", {31'h0, bus.busy}, 32'h0);
      chk("rsplit_strb", {28'h0, bus.mem_strb}, 32'h0);
      chk("rsplit_valid", {31'h0, bus.resp_valid}, 32'h0);
      chk("rsplit_rdata", bus.resp_rdata, 32'h0);
      bus.req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      ref_mem[9'h0F1] = 8'h44;
      ref_mem[9'h0F2] = 8'h33;
      ref_mem[9'h0F3] = 8'h22;
      v = '{1'b0, 3'd2, 9'h0F0, 32'h0, 1'b0, 9'h0F0, 4'hF, 32'h0, 9'h0, 4'h0, 32'h0, 32'h22334400};
      issue(v, 1'b1, "rsplit_lw_lo");
      v = '{1'b0, 3'd2, 9'h0F4, 32'h0, 1'b0, 9'h0F4, 4'hF, 32'h0, 9'h0, 4'h0, 32'h0, 32'h00000000};
      issue(v, 1'b1, "rsplit_lw_hi");

      // Random back-to-back traffic checked against the byte model.
      for (int n = 0; n < 60; n++) begin
         v = '{1'b0, 3'd0, 9'h0, 32'h0, 1'b0, 9'h0, 4'h0, 32'h0, 9'h0, 4'h0, 32'h0, 32'h0};
         v.we = 1'($urandom_range(0, 1));
         if (v.we) v.f3 = 3'($urandom_range(0, 2));
         else begin
            case ($urandom_range(0, 4))
               0: v.f3 = 3'd0;
               1: v.f3 = 3'd1;
               2: v.f3 = 3'd2;
               3: v.f3 = 3'd4;
               default: v.f3 = 3'd5;
            endcase
         end
         v.addr  = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(9'h1F8, 9'h1FF))
                                               : 9'($urandom_range(9'h040, 9'h05F));
         v.wdata = $urandom;
         v.split = (int'(v.addr[1:0]) + nbytes(v.f3)) > 4;
         if (!v.we) v.rdata = model_load(v.f3, v.addr);
         issue(v, 1'b0, $sformatf("r%0d", n));
      end
      bus.req_valid = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk("sb_drained", sb.size(), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/lsu_align_unit.md
Name: lsu_align_unit

Overview:
- MEM-stage load/store unit that sits directly upstream of the byte-strobed data memory.
- Converts pipeline load/store requests (funct3, byte address, store data) into word-aligned memory accesses with byte strobes, and sign/zero-extends load data.
- Misaligned half/word accesses that cross a word boundary are split into two sequential aligned accesses; the pipeline is stalled for one cycle while this happens.
- Memory read port is combinational; memory write is synchronous on clk.

Parameters:
- ADDR_W, 9, byte-address width of the memory port (128 words × 4 bytes).
- XLEN, 32, data width; only 32 is supported.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  load/store request present this cycle
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I size/sign code
- req_addr  input  32  byte address; only [ADDR_W-1:0] is used
- req_wdata  input  32  store data, right-justified
- busy  output  1  combinational stall; pipeline holds the request stable while it is high
- resp_valid  output  1  one-cycle pulse, load data valid
- resp_rdata  output  32  extended load result
- resp_err  output  1  one-cycle pulse, illegal funct3
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  word-aligned byte address; [1:0] is always 00
- mem_wdata  output  32  lane-aligned write data
- mem_strb  output  4  byte strobes
- mem_rdata  input  32  combinational read word

Behaviour:
- Reset is asynchronous, active-low on reset; clock is clk. Reset clears the FSM to IDLE and zeroes all latched request registers, resp_rdata, resp_valid, and resp_err.
- While reset is asserted, busy, mem_we, and mem_strb are 0. Reset mid-split aborts the split; the second access is never issued.
- Size and legality:
  - Loads: funct3 000 = LB, 001 = LH, 010 = LW, 100 = LBU, 101 = LHU.
  - Stores: 000 = SB, 001 = SH, 010 = SW.
  - Any other code is illegal. An illegal request performs no access (mem_we = 0) and pulses resp_err the next cycle. resp_valid is not asserted for it.
- Request decode:
  - off = addr[1:0].
  - nbytes = 1, 2, or 4.
  - Byte mask m = (2^nbytes − 1) << off, evaluated as an 8-bit value.
  - A request is a split request when m[7:4] != 0.
- FSM states are IDLE and HI.
- IDLE, non-split request:
  - mem_addr = {addr[ADDR_W-1:2], 00}.
  - mem_strb = m[3:0] for stores, 4'b1111 for loads.
  - mem_wdata = wdata << 8*off.
  - mem_we = req_we.
  - busy = 0.
  - For a load, the extended result is registered: resp_valid and resp_rdata appear on the next cycle (latency 1).
  - Remain in IDLE.
- IDLE, split request:
  - Issue the low access at the aligned address with strb = m[3:0] (stores) and the same shifted wdata.
  - Latch the request. For a load, latch mem_rdata into lo_reg.
  - busy = 1. Next state is HI.
- HI:
  - All request inputs are ignored; the latched copy is used.
  - mem_addr = latched aligned address + 4, wrapping modulo 2^ADDR_W.
  - mem_strb = m[7:4] for stores, 1111 for loads.
  - mem_wdata = wdata >> 8*(4 − off).
  - busy = 0, so the pipeline advances at the end of this cycle.
  - For a load: {mem_rdata, lo_reg} >> 8*off, keep the low nbytes bytes, extend, register. resp_valid pulses the next cycle (load latency 2 from the first cycle).
  - Next state is IDLE.
- Extension:
  - LB sign-extends bit 7; LH sign-extends bit 15.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- resp_rdata holds its value until the next load response.
- When idle (req_valid = 0), mem_we = 0, mem_strb = 0, and mem_addr = 0.
- A store never asserts resp_valid.
- Back-to-back requests are accepted every cycle in IDLE. A request arriving in the cycle after HI is accepted normally.

Test Plan:
- Aligned words: SW addr 0x010, data 0xDEADBEEF → one cycle with mem_we = 1, strb 1111, mem_addr 0x010. Then LW 0x010 → resp_valid the next cycle with 0xDEADBEEF, busy never high.
- Byte lanes and extension: memory word at 0x020 = 0x80FF7F01.
  - LB 0x023 → 0xFFFFFF80.
  - LBU 0x023 → 0x00000080.
  - LH 0x022 → 0xFFFF80FF.
  - LHU 0x022 → 0x000080FF.
- Byte store lanes: SB 0x025 with data 0x000000AB → strb 0010, mem_wdata[15:8] = 0xAB.
- Split store: SW 0x031, data 0x44332211.
  - Cycle 0: addr 0x030, strb 1110, wdata 0x33221100, busy = 1.
  - Cycle 1: addr 0x034, strb 0001, wdata 0x00000044, busy = 0.
  - Read-back via LW 0x031 → 0x44332211 after a 2-cycle latency.
- Split halfword: SH 0x037, data 0x0000BEEF → strb 1000 at 0x034, then strb 0001 at 0x038. Then LH 0x037 → 0xFFFFBEEF.
- Boundary and error cases:
  - SW at 0x1FE → second access wraps to mem_addr 0x000.
  - funct3 = 011 load → no access, resp_err pulses once.
  - Reset asserted during HI → mem_we = 0 immediately, state IDLE, resp_valid = 0.
